vend_controller: RTL and testbench
==================================

# vend_controller

Transaction controller for the vending machine. It accumulates inserted coin value, validates product selections against fixed prices, and sequences the dispenser handshake. It then returns change coin-by-coin through the coin-return handshake. It sits between the coin acceptor / keypad front end and the dispenser and change-hopper mechanisms. All money is in units of R$0.10.

## Interface
- PRICE_CHOC, 12, chocolate price (R$1.20)
- PRICE_COFFEE, 10, coffee price (R$1.00)
- PRICE_JUICE, 7, juice price (R$0.70)
- MAX_CREDIT, 50, maximum credit held (R$5.00); must be ≤ 63
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- coin_valid  in  1  one-cycle strobe, coin presented
- coin_type  in  2  00=R$0.10 (1), 01=R$0.50 (5), 10=R$1.00 (10), 11=invalid
- sel_valid  in  1  one-cycle strobe, keypad selection
- sel  in  2  0=chocolate, 1=coffee, 2=juice, 3=cancel
- dispense_ack  in  1  dispenser done with current item
- change_ack  in  1  hopper has ejected current coin
- dispense_req  out  1  level, item requested
- dispense_item  out  2  item code, valid while dispense_req
- change_req  out  1  level, coin ejection requested
- change_coin  out  2  coin code (00/01/10 as coin_type), valid while change_req
- credit  out  6  current credit, registered
- busy  out  1  high in DISPENSE or CHANGE
- coin_reject  out  1  one-cycle pulse, coin not credited
- sel_reject  out  1  one-cycle pulse, selection refused

## Operation
- States: IDLE, DISPENSE, CHANGE. Reset enters IDLE; credit=0 and every output=0.
- IDLE, coin_valid only:
  - coin_type 11 -> coin_reject.
  - credit+value > MAX_CREDIT -> coin_reject; credit unchanged.
  - Otherwise credit += value.
- IDLE, sel_valid product (0..2):
  - credit ≥ price -> credit -= price, dispense_item=sel, dispense_req=1, go DISPENSE.
  - Otherwise sel_reject; stay in IDLE.
- IDLE, sel_valid cancel (3): credit>0 -> go CHANGE; credit==0 -> ignored, no pulse.
- IDLE, coin_valid and sel_valid in the same cycle: coin rejected (coin_reject); selection processed as above.
- DISPENSE: dispense_req held until dispense_ack is sampled high. On ack: dispense_req=0, then go CHANGE if credit>0, else IDLE.
- CHANGE, greedy coin choice: R$1.00 if credit≥10, else R$0.50 if credit≥5, else R$0.10.
  - change_req=1 with change_coin; both held until change_ack.
  - On ack: credit -= coin value; change_req=0 for at least one cycle.
  - Next coin is issued on the following cycle; credit==0 after the ack -> IDLE.
- In DISPENSE/CHANGE: any coin_valid -> coin_reject; any sel_valid -> sel_reject; credit changes only as described above.
- dispense_ack or change_ack arriving while the matching req is low: ignored.
- Arithmetic: 6-bit unsigned. Overflow is impossible by the MAX_CREDIT check. Underflow is impossible by the greedy rule.

## Timing
- All outputs registered; strobes sampled on the rising clock edge.
- Coin accepted at edge N -> credit updated, visible after edge N.
- Valid selection at edge N -> dispense_req high and credit reduced after edge N.
- coin_reject / sel_reject: high exactly one cycle, starting after the sampling edge.
- dispense_ack sampled at edge M -> dispense_req low after M. If change is owed, change_req rises after edge M+1.
- Per change coin: req rises, ack at edge K, req low after K, next req after K+1. Minimum 2 cycles per coin.
- busy=1 from the cycle dispense_req rises, or from the cycle after cancel, until the cycle the FSM returns to IDLE.
- Reset asserted mid-transaction: immediate return to IDLE. Credit is forfeited, req lines drop asynchronously, and no change is issued.

## Test plan
- Insert R$1.00 and R$0.50 (credit=15), select chocolate:
  - dispense_req with item 0 and credit=3; ack.
  - Three change_req of R$0.10, each acked; credit=0; IDLE.
- Credit=5, select coffee -> sel_reject one cycle; credit stays 5; no dispense_req.
- Credit=45, insert R$1.00 -> coin_reject; credit 45. Then insert R$0.50 -> credit 50.
- Credit=16, cancel -> change sequence R$1.00, R$0.50, R$0.10; credit 6, 1, 0; busy drops after the last ack.
- Credit=7, select juice -> dispense, then ack -> IDLE with no change_req. A coin during DISPENSE -> coin_reject, credit stays 0.
- Reset low during CHANGE with credit=10 -> all outputs 0 immediately. After release, IDLE with credit=0.

Source files
------------

// File: rtl/vend_controller.sv
// Vending transaction controller: coin credit, priced selection, dispenser
// handshake and greedy coin-by-coin change return.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | accepting coins and keypad selections
// DISPENSE | dispense_req held until the dispenser acknowledges
// CHANGE   | returning remaining credit one coin at a time via the hopper
module vend_controller #(
    parameter int PRICE_CHOC   = 12,
    parameter int PRICE_COFFEE = 10,
    parameter int PRICE_JUICE  = 7,
    parameter int MAX_CREDIT   = 50
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       dispense_ack,
    input  logic       change_ack,
    output logic       dispense_req,
    output logic [1:0] dispense_item,
    output logic       change_req,
    output logic [1:0] change_coin,
    output logic [5:0] credit,
    output logic       busy,
    output logic       coin_reject,
    output logic       sel_reject
);

    typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE} state_t;
    state_t state;

    function automatic logic [5:0] coin_value(input logic [1:0] code);
        case (code)
            2'b00:   coin_value = 6'd1;
            2'b01:   coin_value = 6'd5;
            2'b10:   coin_value = 6'd10;
            default: coin_value = 6'd0;
        endcase
    endfunction

    function automatic logic [1:0] greedy_coin(input logic [5:0] amount);
        if (amount >= 6'd10)
            greedy_coin = 2'b10;
        else if (amount >= 6'd5)
            greedy_coin = 2'b01;
        else
            greedy_coin = 2'b00;
    endfunction

    logic [5:0] price;
    logic [6:0] coin_sum;
    logic       coin_ok;
    logic [5:0] change_left;

    always_comb begin
        price = '0;
        case (sel)
            2'd0:    price = 6'(PRICE_CHOC);
            2'd1:    price = 6'(PRICE_COFFEE);
            2'd2:    price = 6'(PRICE_JUICE);
            default: price = '0;
        endcase
    end

    // 7-bit sum so the ceiling compare cannot wrap
    assign coin_sum    = {1'b0, credit} + {1'b0, coin_value(coin_type)};
    assign coin_ok     = (coin_type != 2'b11) && (coin_sum <= 7'(MAX_CREDIT));
    assign change_left = credit - coin_value(change_coin);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            credit        <= '0;
            dispense_req  <= 1'b0;
            dispense_item <= '0;
            change_req    <= 1'b0;
            change_coin   <= '0;
            busy          <= 1'b0;
            coin_reject   <= 1'b0;
            sel_reject    <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            sel_reject  <= 1'b0;
            case (state)
                IDLE: begin
                    // a coin arriving together with a selection is never credited
                    if (coin_valid) begin
                        if (sel_valid || !coin_ok)
                            coin_reject <= 1'b1;
                        else
                            credit <= coin_sum[5:0];
                    end
                    if (sel_valid) begin
                        if (sel == 2'd3) begin
                            if (credit != 6'd0) begin
                                state <= CHANGE;
                                busy  <= 1'b1;
                            end
                        end else if (credit >= price) begin
                            credit        <= credit - price;
                            dispense_item <= sel;
                            dispense_req  <= 1'b1;
                            state         <= DISPENSE;
                            busy          <= 1'b1;
                        end else begin
                            sel_reject <= 1'b1;
                        end
                    end
                end
                DISPENSE: begin
                    coin_reject <= coin_valid;
                    sel_reject  <= sel_valid;
                    if (dispense_req && dispense_ack) begin
                        dispense_req <= 1'b0;
                        if (credit != 6'd0) begin
                            state <= CHANGE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_valid;
                    sel_reject  <= sel_valid;
                    if (change_req) begin
                        if (change_ack) begin
                            credit     <= change_left;
                            change_req <= 1'b0;
                            if (change_left == 6'd0) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end
                    end else begin
                        change_req  <= 1'b1;
                        change_coin <= greedy_coin(credit);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: purchases, rejects, cancel/change
// sequences and asynchronous reset mid-transaction.
module tb_vend_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       dispense_ack = 1'b0;
    logic       change_ack = 1'b0;
    logic       dispense_req;
    logic [1:0] dispense_item;
    logic       change_req;
    logic [1:0] change_coin;
    logic [5:0] credit;
    logic       busy;
    logic       coin_reject;
    logic       sel_reject;

    int checks = 0;
    int errors = 0;

    vend_controller dut (
        .clock(clock), .reset(reset),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .sel_valid(sel_valid), .sel(sel),
        .dispense_ack(dispense_ack), .change_ack(change_ack),
        .dispense_req(dispense_req), .dispense_item(dispense_item),
        .change_req(change_req), .change_coin(change_coin),
        .credit(credit), .busy(busy),
        .coin_reject(coin_reject), .sel_reject(sel_reject)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [1:0] s);
        sel_valid = 1'b1;
        sel       = s;
        tick();
        sel_valid = 1'b0;
    endtask

    // one change coin: req rises, check code, ack, check req drop and credit
    task automatic change_step(input string tag, input logic [1:0] c, input int after);
        tick();
        check({tag, "_req"}, int'(change_req), 1);
        check({tag, "_coin"}, int'(change_coin), int'(c));
        change_ack = 1'b1;
        tick();
        change_ack = 1'b0;
        check({tag, "_req_low"}, int'(change_req), 0);
        check({tag, "_credit"}, int'(credit), after);
    endtask

    initial begin
        repeat (2) tick();
        check("rst_credit", int'(credit), 0);
        check("rst_outs", int'({dispense_req, change_req, busy, coin_reject, sel_reject}), 0);
        reset = 1'b1;
        tick();

        // chocolate from 15, change 3 x R$0.10
        coin(2'b10);
        check("t1_credit10", int'(credit), 10);
        coin(2'b01);
        check("t1_credit15", int'(credit), 15);
        select(2'd0);
        check("t1_dreq", int'(dispense_req), 1);
        check("t1_item", int'(dispense_item), 0);
        check("t1_credit3", int'(credit), 3);
        check("t1_busy", int'(busy), 1);
        tick();
        check("t1_dreq_hold", int'(dispense_req), 1);
        dispense_ack = 1'b1;
        tick();
        dispense_ack = 1'b0;
        check("t1_dreq_low", int'(dispense_req), 0);
        check("t1_creq_wait", int'(change_req), 0);
        change_step("t1_c1", 2'b00, 2);
        change_step("t1_c2", 2'b00, 1);
        change_step("t1_c3", 2'b00, 0);
        check("t1_idle", int'(busy), 0);

        // stray ack in IDLE is ignored
        dispense_ack = 1'b1;
        tick();
        dispense_ack = 1'b0;
        check("stray_ack", int'({dispense_req, change_req, busy}), 0);

        // insufficient credit for coffee
        coin(2'b01);
        select(2'd1);
        check("t2_srej", int'(sel_reject), 1);
        check("t2_credit", int'(credit), 5);
        check("t2_nodreq", int'(dispense_req), 0);
        tick();
        check("t2_srej_pulse", int'(sel_reject), 0);

        // credit ceiling
        for (int i = 0; i < 4; i++) coin(2'b10);
        check("t3_credit45", int'(credit), 45);
        coin(2'b10);
        check("t3_crej", int'(coin_reject), 1);
        check("t3_credit_keep", int'(credit), 45);
        coin(2'b01);
        check("t3_crej_pulse", int'(coin_reject), 0);
        check("t3_credit50", int'(credit), 50);
        coin(2'b00);
        check("t3_full_rej", int'(coin_reject), 1);
        coin(2'b11);
        check("t3_invalid_rej", int'(coin_reject), 1);
        check("t3_credit50b", int'(credit), 50);
        select(2'd3);
        for (int i = 0; i < 5; i++) change_step("t3_refund", 2'b10, 40 - 10 * i);
        check("t3_idle", int'(busy), 0);

        // coin with cancel at zero credit: coin rejected, cancel ignored
        coin_valid = 1'b1; coin_type = 2'b10; sel_valid = 1'b1; sel = 2'd3;
        tick();
        coin_valid = 1'b0; sel_valid = 1'b0;
        check("both_crej", int'(coin_reject), 1);
        check("both_srej", int'(sel_reject), 0);
        check("both_state", int'({credit, busy}), 0);

        // cancel 16: 10, 5, 1
        coin(2'b10); coin(2'b01); coin(2'b00);
        check("t4_credit16", int'(credit), 16);
        select(2'd3);
        check("t4_busy", int'(busy), 1);
        check("t4_creq_wait", int'(change_req), 0);
        change_step("t4_c1", 2'b10, 6);
        change_step("t4_c2", 2'b01, 1);
        change_step("t4_c3", 2'b00, 0);
        check("t4_busy_low", int'(busy), 0);

        // juice from exactly 7, no change; coin/sel during dispense rejected
        coin(2'b01); coin(2'b00); coin(2'b00);
        select(2'd2);
        check("t5_dreq", int'(dispense_req), 1);
        check("t5_item", int'(dispense_item), 2);
        check("t5_credit0", int'(credit), 0);
        coin(2'b00);
        check("t5_crej", int'(coin_reject), 1);
        check("t5_credit_keep", int'(credit), 0);
        select(2'd1);
        check("t5_srej", int'(sel_reject), 1);
        dispense_ack = 1'b1;
        tick();
        dispense_ack = 1'b0;
        check("t5_done", int'({dispense_req, busy}), 0);
        tick();
        check("t5_no_change", int'(change_req), 0);

        // async reset during change
        coin(2'b10);
        select(2'd3);
        tick();
        check("t6_creq", int'(change_req), 1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_outs", int'({dispense_req, change_req, busy, coin_reject, sel_reject}), 0);
        check("t6_async_credit", int'(credit), 0);
        #3 reset = 1'b1;
        tick();
        tick();
        check("t6_after", int'({credit, busy, change_req}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
